sipo_deserializer8: RTL and testbench
=====================================

# sipo_deserializer8

Serial-in/parallel-out deserializer that collects eight qualified serial bits, MSB first, into a byte. It presents the byte on a holding register with a Valid/Ack handshake. It sits directly downstream of the positive-edge dFlipFlop storage cell: every state bit is a dFlipFlop instance, and the block adds only next-state gating around them. It is the first word-level stage consuming the bit-level serial stream.

## Interface
Parameters:
- none. Word width is fixed at 8 and the bit counter at 3 bits.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- R  input  1  reset, asynchronous, active-low. R=0 forces all state to 0 immediately, independent of Clk.
- Din  input  1  serial data bit, sampled only when En=1.
- En  input  1  bit-qualify strobe; one bit is accepted per rising edge with En=1.
- Ack  input  1  consumer acknowledge; meaningful only while Valid=1.
- Dout  output  8  holding register, the last completed byte. The first received bit is Dout[7].
- Valid  output  1  Dout holds an unconsumed byte.
- Ovf  output  1  sticky overflow flag; a completed byte was dropped.
- BitCnt  output  3  number of bits accepted into the current partial byte (0–7).

## Operation
- State:
  - shift register SR[7:0]
  - counter BitCnt[2:0]
  - holding register Dout[7:0]
  - flags Valid and Ovf
  - total 21 dFlipFlop instances
- Reset (R=0, asynchronous):
  - SR=0x00, BitCnt=0, Dout=0x00, Valid=0, Ovf=0.
  - Release is synchronous to the next rising edge; the first En is honoured on the first edge after R=1.
- Shift: on an edge with En=1, SR <= {SR[6:0], Din} and BitCnt <= BitCnt+1 (mod 8). With En=0, SR and BitCnt hold.
- Completion: an edge with En=1 and BitCnt=7 is the 8th bit.
  - The completed word W = {SR[6:0], Din}.
  - BitCnt wraps to 0 on the same edge.
  - SR still updates to W. The next byte's bits shift W out; SR is not cleared.
- Transfer rule on a completion edge:
  - Valid=0 → Dout<=W, Valid<=1.
  - Valid=1 and Ack=1 → the old byte is consumed and the new one accepted in the same cycle: Dout<=W, Valid stays 1.
  - Valid=1 and Ack=0 → W is dropped, Dout and Valid hold, Ovf<=1.
- Consume: on a non-completion edge with Valid=1 and Ack=1, Valid<=0. Dout holds its stale value (no clearing).
- Ack while Valid=0 is ignored: no state change, no error.
- Ovf is sticky. It clears only on reset, and Ack does not clear it.
- Shift state is independent of the handshake: accepting serial bits never stalls, whatever Valid/Ack do.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: Valid rises at the rising edge that samples the 8th En-qualified bit. Dout carries the new byte from that same edge.
- Back-to-back bytes with En held high make a completion every 8 cycles. A consumer asserting Ack within 8 cycles of Valid rising never causes overflow.
- Valid falls one edge after Ack is sampled high, unless a completion coincides with that edge.
- Asynchronous reset mid-byte discards the partial byte (BitCnt=0) and any unconsumed Dout. Outputs reach their reset values without a clock edge.
- Din and En must meet setup/hold to the Clk rising edge. Inputs are not synchronised internally.

## Test plan
- Reset: drive R=0 mid-operation with Clk stopped → Dout=0x00, Valid=0, Ovf=0, BitCnt=0 immediately.
- Single byte: after reset, shift 1,0,1,0,0,1,0,1 with En=1 → BitCnt counts 1..7 then 0. Valid rises on the 8th edge with Dout=0xA5. Assert Ack for one cycle → Valid=0 next edge, Dout stays 0xA5.
- Gapped strobe: send 0x3C with En deasserted for 3 cycles between bits 4 and 5, with Din toggling during the gap → Dout=0x3C. BitCnt holds at 4 throughout the gap.
- Simultaneous Ack/completion: hold Valid=1 with Dout=0x11, stream 0x22 with Ack=1 on its 8th edge → Dout=0x22, Valid stays 1, Ovf=0.
- Overflow: Valid=1 with Dout=0x11, stream 0x33 with Ack=0 → Dout=0x11, Valid=1, Ovf=1. A later Ack clears Valid but Ovf stays 1 until R=0.
- Back-to-back: stream 0xFF then 0x00 continuously with En=1, Ack asserted 2 cycles after each Valid rise → Dout sequence 0xFF then 0x00, Ovf=0.

Source files
------------

// File: rtl/sipo_deserializer8.sv
// Eight-bit MSB-first serial-in/parallel-out deserializer with a Valid/Ack holding register.
// Every state bit is a dFlipFlop instance; the top adds only the next-state gating.

module dFlipFlop (
  input  logic Clk,
  input  logic R,
  input  logic D,
  output logic Q
);

  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values, whatever the evaluation order.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) Q <= 1'b0;
    else    Q <= D;
  end

endmodule

module sipo_deserializer8 (
  input  logic       Clk,
  input  logic       R,
  input  logic       Din,
  input  logic       En,
  input  logic       Ack,
  output logic [7:0] Dout,
  output logic       Valid,
  output logic       Ovf,
  output logic [2:0] BitCnt
);

  localparam int unsigned NUM_FF = 21;

  logic [7:0]        sr;
  logic [7:0]        sr_next;
  logic [2:0]        cnt_next;
  logic [7:0]        dout_next;
  logic              valid_next;
  logic              ovf_next;
  logic [7:0]        word;
  logic              complete;
  logic [NUM_FF-1:0] d_vec;
  logic [NUM_FF-1:0] q_vec;

  assign word     = {sr[6:0], Din};
  assign complete = En && (BitCnt == 3'd7);

  // NOTE: every signal gets a default first, so no path through this block can infer a latch.
  always_comb begin
    sr_next    = sr;
    cnt_next   = BitCnt;
    dout_next  = Dout;
    valid_next = Valid;
    ovf_next   = Ovf;

    // Shifting never waits on the handshake.
    if (En) begin
      sr_next  = word;
      cnt_next = BitCnt + 3'd1;
    end

    if (complete) begin
      if (!Valid || Ack) begin
        dout_next  = word;
        valid_next = 1'b1;
      end else begin
        ovf_next = 1'b1;
      end
    end else if (Valid && Ack) begin
      valid_next = 1'b0;
    end
  end

  // Bit layout: {Ovf, Valid, Dout[7:0], BitCnt[2:0], SR[7:0]}.
  assign d_vec = {ovf_next, valid_next, dout_next, cnt_next, sr_next};

  for (genvar i = 0; i < NUM_FF; i++) begin : g_ff
    dFlipFlop u_ff (
      .Clk (Clk),
      .R   (R),
      .D   (d_vec[i]),
      .Q   (q_vec[i])
    );
  end

  assign sr     = q_vec[7:0];
  assign BitCnt = q_vec[10:8];
  assign Dout   = q_vec[18:11];
  assign Valid  = q_vec[19];
  assign Ovf    = q_vec[20];

endmodule

// File: tb/tb_sipo_deserializer8.sv
// Directed self-checking bench for sipo_deserializer8: reset, shifting, gaps, handshake, overflow.

module tb_sipo_deserializer8;

  logic       Clk;
  logic       R;
  logic       Din;
  logic       En;
  logic       Ack;
  logic [7:0] Dout;
  logic       Valid;
  logic       Ovf;
  logic [2:0] BitCnt;

  logic clk_run;
  int   n_tests;
  int   n_fail;

  sipo_deserializer8 dut (
    .Clk    (Clk),
    .R      (R),
    .Din    (Din),
    .En     (En),
    .Ack    (Ack),
    .Dout   (Dout),
    .Valid  (Valid),
    .Ovf    (Ovf),
    .BitCnt (BitCnt)
  );

  initial begin
    Clk = 1'b0;
    forever begin
      #5;
      if (clk_run) Clk = ~Clk;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Shift one byte MSB first with En held high; ack_last drives Ack on the 8th edge only.
  task automatic send_byte(input logic [7:0] b, input logic ack_last, input string tag);
    for (int i = 0; i < 8; i++) begin
      En  = 1'b1;
      Din = b[7-i];
      Ack = (i == 7) ? ack_last : 1'b0;
      tick();
      check($sformatf("%s_cnt%0d", tag, i), {5'd0, BitCnt}, 8'((i + 1) % 8));
    end
    En  = 1'b0;
    Ack = 1'b0;
    Din = 1'b0;
  endtask

  task automatic ack_once();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  initial begin
    logic [7:0] gap_byte;
    n_tests = 0;
    n_fail  = 0;
    clk_run = 1'b1;
    R   = 1'b0;
    Din = 1'b0;
    En  = 1'b0;
    Ack = 1'b0;

    // Reset state
    #12;
    check("rst_dout",  Dout, 8'h00);
    check("rst_valid", {7'd0, Valid}, 8'h00);
    check("rst_ovf",   {7'd0, Ovf}, 8'h00);
    check("rst_cnt",   {5'd0, BitCnt}, 8'h00);
    tick();
    R = 1'b1;

    // Single byte 0xA5 then one-cycle Ack
    send_byte(8'hA5, 1'b0, "a5");
    check("a5_valid", {7'd0, Valid}, 8'h01);
    check("a5_dout",  Dout, 8'hA5);
    ack_once();
    check("a5_ack_valid", {7'd0, Valid}, 8'h00);
    check("a5_ack_dout",  Dout, 8'hA5);

    // Ack while Valid=0 is ignored
    ack_once();
    check("idle_ack_valid", {7'd0, Valid}, 8'h00);
    check("idle_ack_ovf",   {7'd0, Ovf}, 8'h00);

    // Gapped strobe: 0x3C with a 3-cycle En gap after bit 4
    gap_byte = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          En  = 1'b0;
          Din = g[0];
          tick();
          check($sformatf("gap_hold%0d", g), {5'd0, BitCnt}, 8'd4);
        end
      end
      En  = 1'b1;
      Din = gap_byte[7-i];
      tick();
      check($sformatf("gap_cnt%0d", i), {5'd0, BitCnt}, 8'((i + 1) % 8));
    end
    En = 1'b0;
    check("gap_valid", {7'd0, Valid}, 8'h01);
    check("gap_dout",  Dout, 8'h3C);
    ack_once();
    check("gap_ack_valid", {7'd0, Valid}, 8'h00);

    // Ack coincident with completion replaces the byte
    send_byte(8'h11, 1'b0, "s11");
    check("s11_dout", Dout, 8'h11);
    send_byte(8'h22, 1'b1, "s22");
    check("sim_dout",  Dout, 8'h22);
    check("sim_valid", {7'd0, Valid}, 8'h01);
    check("sim_ovf",   {7'd0, Ovf}, 8'h00);
    ack_once();
    check("sim_ack_valid", {7'd0, Valid}, 8'h00);

    // Overflow: completion with Valid=1 and no Ack
    send_byte(8'h11, 1'b0, "o11");
    send_byte(8'h33, 1'b0, "o33");
    check("ovf_dout",  Dout, 8'h11);
    check("ovf_valid", {7'd0, Valid}, 8'h01);
    check("ovf_flag",  {7'd0, Ovf}, 8'h01);
    ack_once();
    check("ovf_ack_valid", {7'd0, Valid}, 8'h00);
    check("ovf_sticky",    {7'd0, Ovf}, 8'h01);

    // Asynchronous reset mid-byte with the clock stopped
    send_byte(8'h44, 1'b0, "p44");
    for (int i = 0; i < 3; i++) begin
      En  = 1'b1;
      Din = 1'b1;
      tick();
    end
    En = 1'b0;
    check("pre_rst_cnt", {5'd0, BitCnt}, 8'd3);
    clk_run = 1'b0;
    #3;
    R = 1'b0;
    #2;
    check("arst_dout",  Dout, 8'h00);
    check("arst_valid", {7'd0, Valid}, 8'h00);
    check("arst_ovf",   {7'd0, Ovf}, 8'h00);
    check("arst_cnt",   {5'd0, BitCnt}, 8'h00);
    #3;
    R = 1'b1;
    clk_run = 1'b1;
    tick();

    // Back-to-back 0xFF then 0x00, Ack two edges after each Valid rise
    for (int c = 0; c < 18; c++) begin
      En  = (c < 16);
      Din = (c < 8);
      Ack = (c == 9) || (c == 17);
      tick();
      if (c == 7) begin
        check("b2b_ff_dout",  Dout, 8'hFF);
        check("b2b_ff_valid", {7'd0, Valid}, 8'h01);
      end
      if (c == 9)  check("b2b_ack1_valid", {7'd0, Valid}, 8'h00);
      if (c == 15) begin
        check("b2b_00_dout",  Dout, 8'h00);
        check("b2b_00_valid", {7'd0, Valid}, 8'h01);
      end
      if (c == 17) begin
        check("b2b_ack2_valid", {7'd0, Valid}, 8'h00);
        check("b2b_ovf",        {7'd0, Ovf}, 8'h00);
      end
    end
    En  = 1'b0;
    Ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
